// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready bundle for barrel_shifter_pipe: operand stream in, shifted result stream out.
interface barrel_shifter_pipe_if #(
  parameter int W = 8
);
  localparam int AW = $clog2(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [AW-1:0] in_amt;
  logic          in_dir;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;

  modport master (
    output in_valid, in_a, in_amt, in_dir, in_mode, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_amt, in_dir, in_mode, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined W-bit rotate/logical/arithmetic shifter, one register stage per shift-amount bit,
// with a single global advance enable so the whole pipe stalls together under backpressure.
module barrel_shifter_pipe #(
  parameter int W = 8
) (
  input logic clk,
  input logic reset,
  barrel_shifter_pipe_if.slave bus
);
  localparam int AW = $clog2(W);

  logic [W-1:0]  data_q [AW];
  logic          valid_q [AW];
  logic          dir_q [AW];
  logic [1:0]    mode_q [AW];
  logic          fill_q [AW];
  logic [AW-1:0] amt_q [AW-1];
  logic [W-1:0]  data_d [AW];
  logic          fill_in;
  logic          en;

  // Fill is only ever non-zero for arithmetic right, so it alone selects sign extension.
  function automatic logic [W-1:0] shift_step(
    input logic [W-1:0] d,
    input int           sh,
    input logic         dir,
    input logic [1:0]   mode,
    input logic         fill
  );
    logic [W-1:0] ones;
    logic [W-1:0] r;
    ones = '1;
    if (mode == 2'b01 || mode == 2'b10) begin
      if (!dir) r = d << sh;
      else      r = (d >> sh) | (fill ? ~(ones >> sh) : '0);
    end else begin
      if (!dir) r = (d << sh) | (d >> (W - sh));
      else      r = (d >> sh) | (d << (W - sh));
    end
    return r;
  endfunction

  assign fill_in = bus.in_a[W-1] & bus.in_dir & (bus.in_mode == 2'b10);

  assign en            = bus.out_ready | ~valid_q[AW-1];
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[AW-1];
  assign bus.out_y     = data_q[AW-1];

  always_comb begin
    data_d[0] = bus.in_amt[0]
              ? shift_step(bus.in_a, 1, bus.in_dir, bus.in_mode, fill_in)
              : bus.in_a;
    for (int k = 1; k < AW; k++) begin
      data_d[k] = amt_q[k-1][k]
                ? shift_step(data_q[k-1], 1 << k, dir_q[k-1], mode_q[k-1], fill_q[k-1])
                : data_q[k-1];
    end
  end

  // The last stage has no consumer for amt, so only AW-1 stages carry it forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < AW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        dir_q[k]   <= 1'b0;
        mode_q[k]  <= 2'b00;
        fill_q[k]  <= 1'b0;
      end
      for (int k = 0; k < AW - 1; k++) begin
        amt_q[k] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= bus.in_valid;
      data_q[0]  <= data_d[0];
      dir_q[0]   <= bus.in_dir;
      mode_q[0]  <= bus.in_mode;
      fill_q[0]  <= fill_in;
      amt_q[0]   <= bus.in_amt;
      for (int k = 1; k < AW; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_d[k];
        dir_q[k]   <= dir_q[k-1];
        mode_q[k]  <= mode_q[k-1];
        fill_q[k]  <= fill_q[k-1];
      end
      for (int k = 1; k < AW - 1; k++) begin
        amt_q[k] <= amt_q[k-1];
      end
    end
  end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe at W=4, 8 and 32: directed vector table plus a
// scoreboarded W=8 stream covering backpressure and mid-stream reset.
module tb_barrel_shifter_pipe;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.W(4))  bus4 ();
  barrel_shifter_pipe_if #(.W(8))  bus8 ();
  barrel_shifter_pipe_if #(.W(32)) bus32 ();

  barrel_shifter_pipe #(.W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));
  barrel_shifter_pipe #(.W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  barrel_shifter_pipe #(.W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  typedef struct {
    int          w;
    logic [63:0] a;
    int          amt;
    logic        dir;
    logic [1:0]  mode;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          in_count = 0;
  int          out_count = 0;
  int          in_cyc[int];
  int          out_cyc[int];
  logic [63:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Bit-by-bit reference: each output bit looks up its source bit directly.
  function automatic logic [63:0] model_shift(input int w, input logic [63:0] a, input int amt,
                                              input logic dir, input logic [1:0] mode);
    logic [63:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      src = dir ? i + amt : i - amt;
      if (mode == 2'b01 || mode == 2'b10) begin
        if (src >= 0 && src < w)       r[i] = a[src];
        else if (mode == 2'b10 && dir) r[i] = a[w-1];
        else                           r[i] = 1'b0;
      end else begin
        r[i] = a[(src + w) % w];
      end
    end
    return r;
  endfunction

  // Scoreboard on the W=8 instance: push at accept, pop and compare at output transfer.
  always @(negedge clk) begin
    logic [63:0] m;
    if (!reset) begin
      if (bus8.in_valid && bus8.in_ready) begin
        m = model_shift(8, {56'b0, bus8.in_a}, int'(bus8.in_amt), bus8.in_dir, bus8.in_mode);
        sb.push_back(m);
        in_cyc[in_count] = cyc;
        in_count++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        out_cyc[out_count] = cyc;
        out_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_unexpected_output: got 0x%0h, expected no output", bus8.out_y);
        end else begin
          check_output("sb_data", {56'b0, bus8.out_y}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add_vec(input int w, input logic [63:0] a, input int amt,
                                  input logic dir, input logic [1:0] mode, input logic [63:0] exp);
    vec_t v;
    v.w = w; v.a = a; v.amt = amt; v.dir = dir; v.mode = mode; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input int w, input logic v, input logic [63:0] a, input int amt,
                       input logic dir, input logic [1:0] mode);
    case (w)
      4: begin
        bus4.in_valid = v; bus4.in_a = a[3:0]; bus4.in_amt = 2'(amt);
        bus4.in_dir = dir; bus4.in_mode = mode;
      end
      32: begin
        bus32.in_valid = v; bus32.in_a = a[31:0]; bus32.in_amt = 5'(amt);
        bus32.in_dir = dir; bus32.in_mode = mode;
      end
      default: begin
        bus8.in_valid = v; bus8.in_a = a[7:0]; bus8.in_amt = 3'(amt);
        bus8.in_dir = dir; bus8.in_mode = mode;
      end
    endcase
  endtask

  task automatic sample(input int w, output logic v, output logic [63:0] y);
    case (w)
      4:       begin v = bus4.out_valid;  y = {60'b0, bus4.out_y};  end
      32:      begin v = bus32.out_valid; y = {32'b0, bus32.out_y}; end
      default: begin v = bus8.out_valid;  y = {56'b0, bus8.out_y};  end
    endcase
  endtask

  // Latency counts clock edges from the accepting edge until out_valid is seen.
  task automatic apply_stimulus(input vec_t v, output int lat, output logic [63:0] y);
    logic ov;
    drive(v.w, 1'b1, v.a, v.amt, v.dir, v.mode);
    @(posedge clk); #1;
    drive(v.w, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    lat = 1;
    sample(v.w, ov, y);
    while (!ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      sample(v.w, ov, y);
    end
  endtask

  task automatic drive_random8(input logic v);
    drive(8, v, 64'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
  endtask

  task automatic drain8(input int budget);
    int n;
    drive(8, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    bus8.out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || bus8.out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_sb_empty", 64'(sb.size()), 64'd0);
    check_output("drain_in_eq_out", 64'(in_count), 64'(out_count));
  endtask

  initial begin
    int          lat;
    int          base_in;
    int          base_out;
    int          n;
    logic [63:0] y;
    logic [7:0]  y0;
    logic [7:0]  prev_y;
    logic        stalled;

    add_vec(8, 64'h96, 3, 1'b1, 2'b00, 64'hD2);
    add_vec(8, 64'h96, 3, 1'b0, 2'b00, 64'hB4);
    add_vec(8, 64'h96, 2, 1'b1, 2'b01, 64'h25);
    add_vec(8, 64'h96, 2, 1'b1, 2'b10, 64'hE5);
    add_vec(8, 64'h96, 2, 1'b0, 2'b10, 64'h58);
    add_vec(8, 64'h96, 0, 1'b0, 2'b00, 64'h96);
    add_vec(8, 64'h96, 0, 1'b1, 2'b01, 64'h96);
    add_vec(8, 64'h96, 0, 1'b1, 2'b10, 64'h96);
    add_vec(8, 64'h96, 0, 1'b0, 2'b11, 64'h96);
    add_vec(8, 64'h96, 3, 1'b1, 2'b11, 64'hD2);
    add_vec(8, 64'h01, 7, 1'b0, 2'b01, 64'h80);
    add_vec(8, 64'h80, 7, 1'b1, 2'b10, 64'hFF);
    add_vec(8, 64'h80, 7, 1'b1, 2'b01, 64'h01);
    add_vec(8, 64'h80, 1, 1'b0, 2'b00, 64'h01);
    add_vec(4, 64'h9, 1, 1'b1, 2'b00, 64'hC);
    add_vec(4, 64'h9, 3, 1'b0, 2'b00, 64'hC);
    add_vec(4, 64'h9, 2, 1'b1, 2'b10, 64'hE);
    add_vec(4, 64'h8, 3, 1'b1, 2'b10, 64'hF);
    add_vec(4, 64'h8, 3, 1'b1, 2'b01, 64'h1);
    add_vec(4, 64'h9, 0, 1'b1, 2'b10, 64'h9);
    add_vec(32, 64'h80000001, 31, 1'b1, 2'b10, 64'hFFFFFFFF);
    add_vec(32, 64'h80000001, 31, 1'b1, 2'b00, 64'h00000003);
    add_vec(32, 64'h12345678, 4, 1'b0, 2'b00, 64'h23456781);
    add_vec(32, 64'h12345678, 4, 1'b1, 2'b10, 64'h01234567);
    add_vec(32, 64'h12345678, 8, 1'b1, 2'b11, 64'h78123456);
    add_vec(32, 64'h87654321, 16, 1'b1, 2'b10, 64'hFFFF8765);

    reset = 1'b1;
    bus4.out_ready = 1'b1; bus8.out_ready = 1'b1; bus32.out_ready = 1'b1;
    drive(4, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    drive(8, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    drive(32, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    #22;
    check_output("reset_out_valid", 64'(bus8.out_valid), 64'd0);
    check_output("reset_out_y", 64'(bus8.out_y), 64'd0);
    check_output("reset_out_y_w32", 64'(bus32.out_y), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], lat, y);
      check_output($sformatf("latency_w%0d_v%0d", vecs[i].w, i), 64'(lat), 64'($clog2(vecs[i].w)));
      check_output($sformatf("value_w%0d_v%0d", vecs[i].w, i), y, vecs[i].exp);
      @(posedge clk); #1;
    end

    $display("[TB] back-to-back stream");
    base_in = in_count;
    base_out = out_count;
    for (int i = 0; i < 64; i++) begin
      drive(8, 1'b1, 64'($urandom), i % 8, 1'(i >> 5), 2'(i >> 3));
      @(posedge clk); #1;
    end
    drive(8, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    n = 0;
    while (out_count - base_out < 64 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("stream_count", 64'(out_count - base_out), 64'd64);
    if (out_cyc.exists(base_out) && out_cyc.exists(base_out + 63) && in_cyc.exists(base_in)) begin
      check_output("stream_first_latency", 64'(out_cyc[base_out] - in_cyc[base_in]), 64'd3);
      check_output("stream_one_per_cycle", 64'(out_cyc[base_out + 63] - out_cyc[base_out]), 64'd63);
    end else begin
      check_output("stream_outputs_recorded", 64'(out_count - base_out), 64'd64);
    end

    $display("[TB] backpressure");
    n = 0;
    drive_random8(1'b1);
    @(posedge clk); #1;
    while (!bus8.out_valid && n < 10) begin
      drive_random8(1'b1);
      @(posedge clk); #1;
      n++;
    end
    check_output("bp_valid_before_stall", 64'(bus8.out_valid), 64'd1);
    bus8.out_ready = 1'b0;
    drive_random8(1'b1);
    #1;
    check_output("bp_in_ready_low", 64'(bus8.in_ready), 64'd0);
    y0 = bus8.out_y;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_output($sformatf("bp_hold_valid_%0d", c), 64'(bus8.out_valid), 64'd1);
      check_output($sformatf("bp_hold_y_%0d", c), 64'(bus8.out_y), 64'(y0));
      check_output($sformatf("bp_hold_ready_%0d", c), 64'(bus8.in_ready), 64'd0);
      drive_random8(1'b1);
    end
    for (int c = 0; c < 200; c++) begin
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      drive_random8(1'($urandom));
      stalled = bus8.out_valid && !bus8.out_ready;
      prev_y = bus8.out_y;
      @(posedge clk); #1;
      if (stalled) begin
        check_output("rand_stall_valid", 64'(bus8.out_valid), 64'd1);
        check_output("rand_stall_y", 64'(bus8.out_y), 64'(prev_y));
      end
    end
    drain8(40);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      drive_random8(1'b1);
      @(posedge clk); #1;
    end
    drive(8, 1'b0, 64'b0, 0, 1'b0, 2'b00);
    check_output("pre_reset_valid", 64'(bus8.out_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset_valid", 64'(bus8.out_valid), 64'd0);
    check_output("async_reset_y", 64'(bus8.out_y), 64'd0);
    sb.delete();
    in_count = out_count;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("post_reset_idle", 64'(bus8.out_valid), 64'd0);
    base_out = out_count;
    for (int i = 0; i < 4; i++) begin
      drive_random8(1'b1);
      @(posedge clk); #1;
    end
    drain8(20);
    check_output("post_reset_count", 64'(out_count - base_out), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Pipelined, parametrised successor to the 8-bit combinational rotator. It shifts or rotates a W-bit word left or right by 0..W-1 positions, in rotate, logical or arithmetic mode. One register stage per shift-amount bit gives full throughput at high clock rates. A valid/ready handshake on both sides lets it sit between streaming datapath blocks with backpressure.

## Interface
- W, 8, data width; power of two, 4..64
- AW, $clog2(W), shift-amount width; derived, not overridden
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_a  in  W  operand
- in_amt  in  AW  shift amount 0..W-1
- in_dir  in  1  0 = left, 1 = right
- in_mode  in  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (behaves as rotate)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_y  out  W  result

## Operation
- Pipeline has AW stages, S0..S(AW-1).
- Each stage registers: data, valid, dir, mode, fill bit, and the unconsumed amt bits.
- Fill bit is captured at input:
  - in_a[W-1] when mode=10 and dir=1
  - 0 otherwise
- Stage k consumes amt bit k. When that bit is 1, it moves the data by 2^k positions:
  - rotate, left: bits wrap from MSB to LSB
  - rotate, right: bits wrap from LSB to MSB
  - logical, left or right: vacated bits = 0
  - arithmetic, right: vacated MSBs = fill bit
  - arithmetic, left: identical to logical left
- When amt bit k is 0, the stage passes data through unchanged.
- Stage results are order-independent, so the total shift equals in_amt.
- amt=0 returns in_a unchanged in every mode.
- out_y and out_valid are driven directly from the last stage's registers; there is no combinational path from in_* to out_*.
- Payload registers load only when their stage advances.

## Timing
- Reset (asynchronous assert, synchronous release): all stage valid bits = 0, all data/control registers = 0, out_valid = 0, out_y = 0.
- Reset asserted mid-operation discards all in-flight words; nothing is emitted for them.
- Global advance enable: en = out_ready | ~out_valid.
- in_ready = en, combinational from out_ready and the last-stage valid.
- Transfer in occurs when in_valid & in_ready.
- Transfer out occurs when out_valid & out_ready.
- When en=1, every stage loads from its predecessor and S0 loads the input. S0 valid takes in_valid, so it becomes a bubble if in_valid=0.
- When en=0, all stages hold. out_y and out_valid stay stable until accepted (AXI-style: valid is never withdrawn and payload never changes while stalled).
- Latency: a word accepted in cycle t appears with out_valid=1 in cycle t+AW, provided en stays 1. Stall cycles add one-for-one.
- Throughput: one word per cycle when out_ready is held 1.
- Bubbles are not squeezed out: a stall freezes the whole pipe, including empty stages.
- A simultaneous out transfer and in transfer in the same cycle is legal and is the normal streaming case.
- Words exit in acceptance order; none are dropped or duplicated.
- in_* are ignored when in_ready=0.

## Test plan
- Rotate, W=8: in_a=0x96, mode=00. amt=3, dir=1 -> out_y=0xD2. amt=3, dir=0 -> out_y=0xB4. Each output arrives exactly 3 cycles after its accept.
- Logical and arithmetic right, W=8, in_a=0x96, amt=2, dir=1: mode=01 -> 0x25; mode=10 -> 0xE5. Arithmetic left, amt=2 -> 0x58. Also check amt=0 in all modes -> 0x96.
- Streaming, W=8: 64 back-to-back random words with out_ready=1. Check one result per cycle after the first 3-cycle fill, in order, against a reference model. Include every amt 0..7 and all four modes, with mode 11 matching rotate.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1. Check in_ready=0, and that out_y/out_valid are stable. Release, then check no loss or duplication across a random out_ready pattern of 200 cycles.
- Reset mid-stream: assert reset with 3 words in flight. Check out_valid=0 and out_y=0 immediately (asynchronous). After release, new words emerge and none of the pre-reset words appear.
- Parametrisation: repeat the rotate and arithmetic checks at W=4 (latency 2) and W=32 (latency 5). For example, W=32 with in_a=0x80000001, amt=31, dir=1, mode=10 -> 0xFFFFFFFF.
